ram_arbiter: RTL and testbench

Shares one `simple_ram` port between up to four bus masters (6502 core, DMA/loader, video fetch, debug). Each requester issues a single-word read or write with a level `req`. The arbiter grants requesters round-robin, drives the RAM's `cs`/`oe`/`we`/`addr`/`data_in`, captures read data, and returns a one-cycle `ack`. It sits between the masters and the RAM instance in the system top.

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 47 ++++
 rtl/ram_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_arb_pkg : shared state type and sizing constants for ram_arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int MAX_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_picker : combinational round-robin select, first requester after last_grant
// Revision  : 1.0
// ---------------------------------------------------------------------------
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [MAX_REQ-1:0] w_req_ext;

  // Pad to MAX_REQ so the 2-bit index never selects past the vector.
  generate
    for (genvar g = 0; g < MAX_REQ; g++) begin : g_ext
      if (g < NUM_REQ) begin : g_real
        assign w_req_ext[g] = req[g];
      end else begin : g_pad
        assign w_req_ext[g] = 1'b0;
      end
    end
  endgenerate

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int w_idx;
    w_idx  = 0;
    winner = last_grant;
    valid  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = int'(last_grant) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (w_req_ext[w_idx[IDX_W-1:0]]) begin
        winner = w_idx[IDX_W-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_arbiter : round-robin sharing of one single-port RAM among bus masters
// Revision    : 1.0
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ram_cs,
  output logic                          ram_oe,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic                          busy
);

  arb_state_e             r_state;
  arb_state_e             w_state_next;
  logic [IDX_W-1:0]       r_last_grant;
  logic [IDX_W-1:0]       r_grant;
  logic [IDX_W-1:0]       w_winner;
  logic                   w_valid;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_rdata;

  logic                   w_we_arr    [MAX_REQ];
  logic [ADDR_WIDTH-1:0]  w_addr_arr  [MAX_REQ];
  logic [DATA_WIDTH-1:0]  w_wdata_arr [MAX_REQ];

  generate
    for (genvar g = 0; g < MAX_REQ; g++) begin : g_unpack
      if (g < NUM_REQ) begin : g_real
        assign w_we_arr[g]    = req_we[g];
        assign w_addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_pad
        assign w_we_arr[g]    = 1'b0;
        assign w_addr_arr[g]  = '0;
        assign w_wdata_arr[g] = '0;
      end
    end
  endgenerate

  rr_picker #(
    .NUM_REQ    (NUM_REQ)
  ) u_picker (
    .req        (req),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .valid      (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE:   if (w_valid) w_state_next = ARB_ACCESS;
      ARB_ACCESS: w_state_next = ARB_DONE;
      ARB_DONE:   w_state_next = ARB_IDLE;
      default:    w_state_next = ARB_IDLE;
    endcase
  end

  // Operands are frozen at the grant edge; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (r_state == ARB_IDLE && w_valid) begin
      r_last_grant <= w_winner;
      r_grant      <= w_winner;
      r_we         <= w_we_arr[w_winner];
      r_addr       <= w_addr_arr[w_winner];
      r_wdata      <= w_wdata_arr[w_winner];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_rdata <= '0;
    else if (r_state == ARB_ACCESS && !r_we)   r_rdata <= ram_rdata;
  end

  // Controls decode from state so an async reset drops them before any edge.
  assign ram_cs    = (r_state == ARB_ACCESS);
  assign ram_oe    = ram_cs & ~r_we;
  assign ram_we    = ram_cs & r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign rdata     = r_rdata;
  assign busy      = (r_state != ARB_IDLE);

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (r_state == ARB_DONE) && (r_grant == IDX_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ram_arbiter : self-checking bench for ram_arbiter with NUM_REQ=3
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int N  = 3;
  localparam int AW = 15;
  localparam int DW = 8;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            ram_cs, ram_oe, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  wire  [DW-1:0]   ram_rdata;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [N-1:0] hold = '0;

  bit [DW-1:0] mem     [0:(1<<AW)-1];
  bit [DW-1:0] ref_mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  ram_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .ram_cs    (ram_cs),
    .ram_oe    (ram_oe),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  // Behavioural single-port RAM.
  assign ram_rdata = (ram_cs && ram_oe) ? mem[ram_addr] : {DW{1'bz}};
  always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;

  // Transaction model: a grant opens a 2-cycle window (access, then ack).
  int            m_cnt   = 0;
  int            m_last  = N - 1;
  int            m_idx   = 0;
  int            m_c;
  bit            m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_last = N - 1; m_idx = 0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_cnt == 2) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      m_rdata = ref_mem[m_addr];
      m_cnt = 1;
    end else if (m_cnt == 1) begin
      m_cnt = 0;
    end else if (req != '0) begin
      for (int k = 1; k <= N; k++) begin
        m_c = (m_last + k) % N;
        if (req[m_c]) begin
          m_idx = m_c;
          break;
        end
      end
      m_last  = m_idx;
      m_we    = req_we[m_idx];
      m_addr  = req_addr[m_idx*AW +: AW];
      m_wdata = req_wdata[m_idx*DW +: DW];
      m_cnt   = 2;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: compare all outputs with the model, then drop acknowledged requests.
  task automatic step();
    @(negedge clk);
    cyc++;
    check_eq("ack",       32'(ack),       (m_cnt == 1) ? (32'd1 << m_idx) : 32'd0);
    check_eq("busy",      32'(busy),      32'(m_cnt != 0));
    check_eq("ram_cs",    32'(ram_cs),    32'(m_cnt == 2));
    check_eq("ram_oe",    32'(ram_oe),    32'(m_cnt == 2 && !m_we));
    check_eq("ram_we",    32'(ram_we),    32'(m_cnt == 2 && m_we));
    check_eq("ram_addr",  32'(ram_addr),  32'(m_addr));
    check_eq("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    check_eq("rdata",     32'(rdata),     32'(m_rdata));
    for (int i = 0; i < N; i++) if (ack[i] && !hold[i]) req[i] = 1'b0;
  endtask

  task automatic set_ops(input int i, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = addr;
    req_wdata[i*DW +: DW] = wd;
  endtask

  // Issue one access and wait (bounded) for its ack; returns cycles to ack.
  task automatic access(input int i, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    set_ops(i, we, addr, wd);
    req[i] = 1'b1;
    while (!seen && lat < 20) begin
      step();
      lat++;
      if (ack[i]) seen = 1'b1;
    end
    check_eq("ack_seen", 32'(seen), 32'd1);
    req[i] = 1'b0;
    step();
  endtask

  initial begin
    int lat;
    int n_ack;
    int idle_act;
    int order [6];
    int when  [6];

    repeat (3) step();
    check_eq("reset_ack",   32'(ack),    32'd0);
    check_eq("reset_busy",  32'(busy),   32'd0);
    check_eq("reset_rdata", 32'(rdata),  32'd0);
    rst_n = 1'b1;
    step();

    // Preload through requester 1.
    access(1, 1'b1, 15'h0200, 8'hAA, lat);
    access(1, 1'b1, 15'h0201, 8'h55, lat);
    access(1, 1'b1, 15'h0202, 8'h66, lat);

    // Single read
    access(0, 1'b0, 15'h0200, 8'h00, lat);
    check_eq("read_latency", 32'(lat),   32'd2);
    check_eq("read_data",    32'(rdata), 32'hAA);

    // Write then read
    access(1, 1'b1, 15'h1234, 8'h5A, lat);
    check_eq("write_latency", 32'(lat),   32'd2);
    check_eq("write_keeps_rdata", 32'(rdata), 32'hAA);
    access(0, 1'b0, 15'h1234, 8'h00, lat);
    check_eq("wr_rd_data",   32'(rdata), 32'h5A);

    // Operand change after grant
    set_ops(0, 1'b0, 15'h0201, 8'h00);
    req[0] = 1'b1;
    step();
    check_eq("opchg_cs", 32'(ram_cs), 32'd1);
    set_ops(0, 1'b0, 15'h0202, 8'h00);
    step();
    check_eq("opchg_ack",   32'(ack),   32'b001);
    check_eq("opchg_rdata", 32'(rdata), 32'h55);
    req[0] = 1'b0;
    step();

    // Reset during a write's access cycle
    set_ops(0, 1'b1, 15'h0300, 8'h77);
    req[0] = 1'b1;
    step();
    check_eq("rst_pre_we", 32'(ram_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_cs",    32'(ram_cs),    32'd0);
    check_eq("rst_async_we",    32'(ram_we),    32'd0);
    check_eq("rst_async_busy",  32'(busy),      32'd0);
    check_eq("rst_async_ack",   32'(ack),       32'd0);
    check_eq("rst_async_addr",  32'(ram_addr),  32'd0);
    check_eq("rst_async_wdata", 32'(ram_wdata), 32'd0);
    check_eq("rst_async_rdata", 32'(rdata),     32'd0);
    req[0] = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    access(0, 1'b0, 15'h0300, 8'h00, lat);
    check_eq("rst_no_commit", 32'(rdata), 32'h00);

    // Idle bus
    idle_act = 0;
    repeat (20) begin
      step();
      if (ram_cs || busy || ack != '0) idle_act++;
    end
    check_eq("idle_activity", 32'(idle_act), 32'd0);

    // Three-way contention from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) set_ops(i, 1'b0, AW'(16'h0200 + i), 8'h00);
    hold = '1;
    req  = '1;
    n_ack = 0;
    for (int t = 0; t < 40 && n_ack < 6; t++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (ack[i] && n_ack < 6) begin
          order[n_ack] = i;
          when[n_ack]  = cyc;
          n_ack++;
        end
      end
    end
    check_eq("cont_count", 32'(n_ack), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < n_ack) begin
        check_eq("cont_order", 32'(order[k]), 32'(k % 3));
        if (k > 0) check_eq("cont_gap", 32'(when[k] - when[k-1]), 32'd3);
      end
    end
    hold = '0;
    req  = '0;
    repeat (3) step();

    // Randomised traffic, operands may wander while a request is pending
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_ops(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
            req[i] = 1'b1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_ops(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
        end
      end
      step();
    end
    req = '0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
